// File: rtl/rom_download_writer.sv
// rom_download_writer: packs ioctl download bytes into 32-bit words, buffers them and writes them to SDRAM
`timescale 1ns/1ps
module rom_download_writer #(
  parameter int ADDR_WIDTH = 23,
  parameter int FIFO_DEPTH = 4,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ioctl_download,
  input  logic                  ioctl_wr,
  input  logic [24:0]           ioctl_addr,
  input  logic [7:0]            ioctl_data,
  output logic                  ioctl_wait,
  output logic                  sdram_req,
  input  logic                  sdram_ack,
  output logic                  sdram_we,
  output logic [ADDR_WIDTH-1:0] sdram_addr,
  output logic [31:0]           sdram_data,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = ADDR_WIDTH + 32;
  typedef enum logic {IDLE, REQ} state_t;
  state_t state;
  logic dl_q;
  logic [22:0] pk_w;
  logic [31:0] pk_data;
  logic [3:0] pk_mask;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wp, rp;
  logic [PW:0] count, count_next, free;
  logic rise, fall, wr, fresh, push_a, push_b, acc_a, acc_b, pop, all_idle;
  logic [22:0] byte_w;
  logic [1:0] lane;
  logic [31:0] new_data;
  logic [3:0] new_mask;
  logic [EW-1:0] ent_a, ent_b, head;

  function automatic logic [ADDR_WIDTH-1:0] waddr(input logic [22:0] w);
    return ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(w);
  endfunction

  assign rise = ioctl_download & ~dl_q;
  assign fall = ~ioctl_download & dl_q;
  assign wr = ioctl_wr & ioctl_download;
  assign byte_w = ioctl_addr[24:2];
  assign lane = ioctl_addr[1:0];
  assign fresh = rise | ~|pk_mask | (byte_w != pk_w);
  // a byte for a new word can flush the pending word and complete its own word in one cycle
  assign push_a = wr & ~rise & |pk_mask & (byte_w != pk_w);
  assign push_b = (wr & (lane == 2'd3)) | (fall & |pk_mask);

  always_comb begin
    new_data = fresh ? '0 : pk_data;
    new_mask = fresh ? '0 : pk_mask;
    new_data[{lane, 3'b000} +: 8] = ioctl_data;
    new_mask[lane] = 1'b1;
  end

  assign ent_a = {waddr(pk_w), pk_data};
  assign ent_b = wr ? {waddr(byte_w), new_data} : {waddr(pk_w), pk_data};
  assign head = mem[rp];
  assign pop = |count & ((state == IDLE) | sdram_ack);
  assign free = (PW+1)'(FIFO_DEPTH) - count + (PW+1)'(pop);
  assign acc_a = push_a & |free;
  assign acc_b = push_b & (free > (PW+1)'(acc_a));
  assign count_next = count + (PW+1)'(acc_a) + (PW+1)'(acc_b) - (PW+1)'(pop);
  assign all_idle = ~ioctl_download & ~|pk_mask & ~|count & (state == IDLE);

  always_ff @(posedge clk) begin
    if (acc_a) mem[wp] <= ent_a;
    if (acc_b) mem[wp + PW'(acc_a)] <= ent_b;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dl_q <= 1'b0;
      pk_w <= '0;
      pk_data <= '0;
      pk_mask <= '0;
      wp <= '0;
      rp <= '0;
      count <= '0;
      ioctl_wait <= 1'b0;
      overflow <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      dl_q <= ioctl_download;
      wp <= wp + PW'(acc_a) + PW'(acc_b);
      rp <= rp + PW'(pop);
      count <= count_next;
      ioctl_wait <= count_next >= (PW+1)'(FIFO_DEPTH - 1);
      overflow <= overflow | (push_a & ~acc_a) | (push_b & ~acc_b);
      if (wr) begin
        pk_w <= byte_w;
        pk_data <= (lane == 2'd3) ? '0 : new_data;
        pk_mask <= (lane == 2'd3) ? '0 : new_mask;
      end else if (rise | fall) begin
        pk_data <= '0;
        pk_mask <= '0;
      end
      busy <= rise | (busy & ~all_idle);
      done <= busy & all_idle;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sdram_req <= 1'b0;
      sdram_we <= 1'b0;
      sdram_addr <= '0;
      sdram_data <= '0;
    end else if (pop) begin
      {sdram_addr, sdram_data} <= head;
      sdram_req <= 1'b1;
      sdram_we <= 1'b1;
      state <= REQ;
    end else if (state == REQ && sdram_ack) begin
      sdram_req <= 1'b0;
      sdram_we <= 1'b0;
      state <= IDLE;
    end
  end
endmodule
